// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers used by conv2d and maxpool2d.
package cnn_pkg;
  localparam int CNN_DATA_WIDTH = 16;

  typedef logic signed [CNN_DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    MP_IDLE, MP_RD0, MP_RD1, MP_RD2, MP_RD3, MP_CAP, MP_WR, MP_DONE
  } mp_state_t;

  // Address width for a memory of n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Linear index of (ch, r, c) in a CHW feature map with square planes of side sz.
  function automatic int lin3(input int ch, input int r, input int c, input int sz);
    return (ch * sz + r) * sz + c;
  endfunction
endpackage

// File: rtl/maxpool2d_if.sv
// Feature-map read port and pooled-map write port of the max-pool stage.
interface maxpool2d_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_AW      = 1,
  parameter int OUT_AW     = 1
);
  logic [IN_AW-1:0]             in_addr;
  logic                         in_en;
  logic signed [DATA_WIDTH-1:0] in_q;
  logic [OUT_AW-1:0]            out_addr;
  logic                         out_en;
  logic                         out_we;
  logic signed [DATA_WIDTH-1:0] out_d;

  modport master (output in_addr, in_en, out_addr, out_en, out_we, out_d, input in_q);
  modport slave  (input in_addr, in_en, out_addr, out_en, out_we, out_d, output in_q);
endinterface

// File: rtl/maxpool_addr_gen.sv
// Output-pixel scan counters: channel outer, row, column inner, with last-pixel flag.
module maxpool_addr_gen #(
  parameter int CHANNELS = 1,
  parameter int OUT_SIZE = 14,
  parameter int CH_W     = 1,
  parameter int P_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_adv,
  output logic [CH_W-1:0] o_ch,
  output logic [P_W-1:0]  o_orow,
  output logic [P_W-1:0]  o_ocol,
  output logic            o_last
);
  logic [CH_W-1:0] r_ch;
  logic [P_W-1:0]  r_orow, r_ocol;
  logic            w_col_end, w_row_end, w_ch_end;

  assign w_col_end = (r_ocol == P_W'(OUT_SIZE - 1));
  assign w_row_end = (r_orow == P_W'(OUT_SIZE - 1));
  assign w_ch_end  = (r_ch == CH_W'(CHANNELS - 1));

  // Wraps to zero after the last pixel so the next pass starts at the origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch   <= '0;
      r_orow <= '0;
      r_ocol <= '0;
    end else if (i_adv) begin
      if (!w_col_end) begin
        r_ocol <= r_ocol + P_W'(1);
      end else begin
        r_ocol <= '0;
        if (!w_row_end) begin
          r_orow <= r_orow + P_W'(1);
        end else begin
          r_orow <= '0;
          r_ch   <= w_ch_end ? '0 : r_ch + CH_W'(1);
        end
      end
    end
  end

  assign o_ch   = r_ch;
  assign o_orow = r_orow;
  assign o_ocol = r_ocol;
  assign o_last = w_col_end & w_row_end & w_ch_end;
endmodule

// File: rtl/maxpool2d.sv
// 2x2 stride-2 max-pool over a CHW feature map, six cycles per output pixel.
// Define MAXPOOL_RELU_EN to clamp negative results to zero (fused ReLU).
module maxpool2d import cnn_pkg::*; #(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int CHANNELS   = 1,
  parameter int IMG_SIZE   = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  maxpool2d_if.master bus,
  output logic        busy,
  output logic        done
);
  localparam int OUT_SIZE = IMG_SIZE / 2;
  localparam int IN_SZ    = CHANNELS * IMG_SIZE * IMG_SIZE;
  localparam int OUT_SZ   = CHANNELS * OUT_SIZE * OUT_SIZE;
  localparam int IN_AW    = addr_w(IN_SZ);
  localparam int OUT_AW   = addr_w(OUT_SZ);
  localparam int CH_W     = addr_w(CHANNELS);
  localparam int P_W      = addr_w(OUT_SIZE);

  generate
    if (IMG_SIZE < 2 || (IMG_SIZE % 2) != 0) begin : g_bad_img_size
      $error("maxpool2d: IMG_SIZE must be even and at least 2");
    end
  endgenerate

  mp_state_t                    r_state;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic                         r_last;
  logic signed [DATA_WIDTH-1:0] w_merge, w_wr_val;
  logic [CH_W-1:0]              w_ch;
  logic [P_W-1:0]               w_orow, w_ocol;
  logic                         w_last, w_adv;

  // Counters step once the window has been fully read, so the next RD0
  // address is ready when WR exits; out_addr and r_last are latched first.
  assign w_adv = (r_state == MP_CAP);

  maxpool_addr_gen #(
    .CHANNELS (CHANNELS),
    .OUT_SIZE (OUT_SIZE),
    .CH_W     (CH_W),
    .P_W      (P_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .i_adv  (w_adv),
    .o_ch   (w_ch),
    .o_orow (w_orow),
    .o_ocol (w_ocol),
    .o_last (w_last)
  );

  assign w_merge = (bus.in_q > r_max) ? bus.in_q : r_max;
`ifdef MAXPOOL_RELU_EN
  assign w_wr_val = w_merge[DATA_WIDTH-1] ? '0 : w_merge;
`else
  assign w_wr_val = w_merge;
`endif

  function automatic logic [IN_AW-1:0] rd_addr(input logic dr, input logic dc);
    return IN_AW'(lin3(int'(w_ch), 2 * int'(w_orow) + int'(dr),
                       2 * int'(w_ocol) + int'(dc), IMG_SIZE));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= MP_IDLE;
      r_max        <= '0;
      r_last       <= 1'b0;
      bus.in_addr  <= '0;
      bus.in_en    <= 1'b0;
      bus.out_addr <= '0;
      bus.out_en   <= 1'b0;
      bus.out_we   <= 1'b0;
      bus.out_d    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      bus.in_en  <= 1'b0;
      bus.out_en <= 1'b0;
      bus.out_we <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        MP_IDLE: if (start) begin
          r_state     <= MP_RD0;
          bus.in_en   <= 1'b1;
          bus.in_addr <= rd_addr(1'b0, 1'b0);
          busy        <= 1'b1;
        end
        MP_RD0: begin
          r_state     <= MP_RD1;
          bus.in_en   <= 1'b1;
          bus.in_addr <= rd_addr(1'b0, 1'b1);
        end
        MP_RD1: begin
          r_state     <= MP_RD2;
          r_max       <= bus.in_q;
          bus.in_en   <= 1'b1;
          bus.in_addr <= rd_addr(1'b1, 1'b0);
        end
        MP_RD2: begin
          r_state     <= MP_RD3;
          r_max       <= w_merge;
          bus.in_en   <= 1'b1;
          bus.in_addr <= rd_addr(1'b1, 1'b1);
        end
        MP_RD3: begin
          r_state <= MP_CAP;
          r_max   <= w_merge;
        end
        MP_CAP: begin
          r_state      <= MP_WR;
          r_max        <= w_merge;
          r_last       <= w_last;
          bus.out_d    <= w_wr_val;
          bus.out_addr <= OUT_AW'(lin3(int'(w_ch), int'(w_orow), int'(w_ocol), OUT_SIZE));
          bus.out_en   <= 1'b1;
          bus.out_we   <= 1'b1;
        end
        MP_WR: if (r_last) begin
          r_state <= MP_DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end else begin
          r_state     <= MP_RD0;
          bus.in_en   <= 1'b1;
          bus.in_addr <= rd_addr(1'b0, 1'b0);
        end
        MP_DONE: r_state <= MP_IDLE;
        default: r_state <= MP_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool2d.sv
// Randomised bench for maxpool2d (2 channels, 4x4 planes) against a window-max reference.
module tb_maxpool2d;
  localparam int DW     = 16;
  localparam int CH     = 2;
  localparam int IMG    = 4;
  localparam int OS     = IMG / 2;
  localparam int IN_SZ  = CH * IMG * IMG;
  localparam int OUT_SZ = CH * OS * OS;
  localparam int IN_AW  = 5;
  localparam int OUT_AW = 3;

  logic clk, reset, start, busy, done;
  int   tests = 0, errs = 0;
  int   wr_cnt = 0, done_cnt = 0;
  logic signed [DW-1:0] mem [IN_SZ];
  logic signed [DW-1:0] got [OUT_SZ];

  maxpool2d_if #(.DATA_WIDTH(DW), .IN_AW(IN_AW), .OUT_AW(OUT_AW)) mp_bus ();

  maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IMG)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (mp_bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feature-map RAM with one-cycle read latency, pooled-map RAM, pulse counters.
  always @(posedge clk) begin
    if (mp_bus.in_en) mp_bus.in_q <= mem[mp_bus.in_addr];
    if (mp_bus.out_en && mp_bus.out_we) begin
      got[mp_bus.out_addr] <= mp_bus.out_d;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_out(input int n);
    int ch, orow, ocol, m, v;
    ch   = n / (OS * OS);
    orow = (n / OS) % OS;
    ocol = n % OS;
    m    = mem[(ch * IMG + 2 * orow) * IMG + 2 * ocol];
    for (int k = 1; k < 4; k++) begin
      v = mem[(ch * IMG + 2 * orow + k / 2) * IMG + 2 * ocol + k % 2];
      if (v > m) m = v;
    end
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic run_pass(input bit repulse);
    int  cyc = 0, n = 0, w0 = wr_cnt, d0 = done_cnt;
    bit  seen = 0;
    @(negedge clk) start = 1'b1;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start = repulse && (cyc == 3 || cyc == 20);
      if (cyc == 1) chk("busy_rise", busy, 1);
      if (mp_bus.out_en) begin
        chk("wr_cycle", cyc, 6 * (n + 1));
        chk("wr_we", mp_bus.out_we, 1);
        chk("wr_in_en", mp_bus.in_en, 0);
        chk("wr_addr", mp_bus.out_addr, n);
        chk("wr_data", mp_bus.out_d, ref_out(n));
        n++;
      end
      if (done) begin
        seen = 1;
        chk("done_cycle", cyc, 6 * OUT_SZ + 1);
        chk("done_busy", busy, 0);
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pass_writes", wr_cnt - w0, OUT_SZ);
    chk("pass_dones", done_cnt - d0, 1);
  endtask

  task automatic run_abort();
    int w0, d0;
    @(negedge clk) start = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    w0 = wr_cnt;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("abort_in_addr", mp_bus.in_addr, 0);
    chk("abort_in_en", mp_bus.in_en, 0);
    chk("abort_out_addr", mp_bus.out_addr, 0);
    chk("abort_out_strobe", {mp_bus.out_en, mp_bus.out_we}, 0);
    chk("abort_out_d", mp_bus.out_d, 0);
    chk("abort_busy_done", {busy, done}, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    int exp_neg;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in", {mp_bus.in_en, mp_bus.in_addr}, 0);
    chk("rst_out", {mp_bus.out_en, mp_bus.out_we, mp_bus.out_addr, mp_bus.out_d}, 0);
    chk("rst_status", {busy, done}, 0);
    @(negedge clk) reset = 1'b1;

    // Ramp 1..16 per plane, second channel offset by 100.
    for (int i = 0; i < IN_SZ; i++) mem[i] = DW'(i % 16 + 1 + 100 * (i / 16));
    run_pass(1'b0);
    for (int i = 0; i < OUT_SZ; i++)
      chk("ramp_out", got[i], (i / 4) * 100 + ((i % 4) / 2) * 8 + (i % 2) * 2 + 6);

    // All -5 with a single -1 in each window at a varying position.
    for (int i = 0; i < IN_SZ; i++) mem[i] = -16'sd5;
    for (int n = 0; n < OUT_SZ; n++)
      mem[((n / 4) * IMG + 2 * ((n / 2) % 2) + (n % 4) / 2) * IMG + 2 * (n % 2) + n % 2] = -16'sd1;
`ifdef MAXPOOL_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -1;
`endif
    run_pass(1'b1);
    for (int i = 0; i < OUT_SZ; i++) chk("neg_out", got[i], exp_neg);

    // Extremes and ties in the first two windows, random elsewhere.
    for (int i = 0; i < IN_SZ; i++) mem[i] = DW'($urandom);
    mem[0] = -16'sd32768; mem[1] = 16'sd32767; mem[4] = 16'sd0; mem[5] = -16'sd1;
    mem[2] = 16'sd7;      mem[3] = 16'sd7;     mem[6] = 16'sd7; mem[7] = 16'sd7;
    run_pass(1'b0);
    chk("extreme_out", got[0], 32767);
    chk("tie_out", got[1], 7);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < IN_SZ; i++) mem[i] = DW'($urandom);
      run_pass(p == 1);
    end

    run_abort();
    for (int i = 0; i < IN_SZ; i++) mem[i] = DW'($urandom);
    run_pass(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/maxpool2d.md
MAXPOOL2D -- requirements
Module: maxpool2d

Interface
REQ-001 Parameter DATA_WIDTH, 16, signed sample width.
REQ-002 Parameter CHANNELS, 1, number of feature-map channels.
REQ-003 Parameter IMG_SIZE, 28, input height = width; must be even.
REQ-004 Derived constants: OUT_SIZE = IMG_SIZE/2; IN_SZ = CHANNELS*IMG_SIZE^2; OUT_SZ = CHANNELS*OUT_SIZE^2; IN_AW and OUT_AW = max(1, clog2(size)).
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a full pooling pass.
REQ-008 in_addr  output  IN_AW  feature-map read address, written by the upstream conv2d stage.
REQ-009 in_en  output  1  read enable.
REQ-010 in_q  input  DATA_WIDTH  signed read data, valid exactly 1 cycle after in_en.
REQ-011 out_addr  output  OUT_AW  pooled-map write address.
REQ-012 out_en, out_we  output  1 each  write strobe; both high together, for one cycle per output.
REQ-013 out_d  output  DATA_WIDTH  signed pooled value.
REQ-014 busy  output  1  high from the first read until the done cycle.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 Operation SHALL be 2x2 max-pool, stride 2, no padding; index in = (ch*IMG_SIZE+r)*IMG_SIZE+c, out = (ch*OUT_SIZE+orow)*OUT_SIZE+ocol.
REQ-017 Scan order SHALL be channel outer, output row, output column inner.
REQ-018 FSM states SHALL be IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE.
REQ-019 IDLE -> RD0 on start; start SHALL be ignored in every other state.
REQ-020 RD0..RD3 issue in_en=1 with addresses (2orow,2ocol), (2orow,2ocol+1), (2orow+1,2ocol), (2orow+1,2ocol+1), one per cycle.
REQ-021 in_q from RD0 SHALL initialise the running max; data captured in RD2, RD3 and CAP SHALL be merged by signed comparison (ties keep current).
REQ-022 WR SHALL assert out_en=out_we=1 with the final max on out_d; then RD0 for the next pixel, or DONE after the last.
REQ-023 Each output pixel SHALL take exactly 6 cycles; writes for pixel n occur 6(n+1) cycles after the start-sampling edge.
REQ-024 DONE SHALL assert done for one cycle, deassert busy, and return to IDLE; start high in IDLE restarts.
REQ-025 Outside RD0..RD3, in_en SHALL be 0; outside WR, out_en and out_we SHALL be 0.
REQ-026 No arithmetic beyond comparison; out_d SHALL never exceed DATA_WIDTH.
REQ-027 IMG_SIZE odd or less than 2 SHALL fail elaboration.

Reset
REQ-028 On reset low: state IDLE; in_addr, in_en, out_addr, out_en, out_we, out_d, busy, done = 0; counters and running max = 0.
REQ-029 Reset mid-pass SHALL abort immediately; no further write occurs and no done pulse is produced.

Configuration
REQ-030 Macro MAXPOOL_RELU_EN defined: the WR value SHALL be clamped to 0 if negative (fused ReLU); undefined: the raw signed max is written.

Structure
REQ-031 Shared package cnn_pkg SHALL hold the data_t signed typedef, DATA_WIDTH default and the lin3 index function used by conv2d and maxpool2d.
REQ-032 Sub-module maxpool_addr_gen SHALL hold the ch/orow/ocol counters with a last-pixel flag; the FSM and comparator stay in maxpool2d.

Verification
REQ-033 IMG_SIZE=4, CHANNELS=1, input 1..16 row-major -> out {6,8,14,16} at addresses 0..3, done 25 cycles after start.
REQ-034 All inputs -5, window maxima -1 -> out 0 with MAXPOOL_RELU_EN, -1 without.
REQ-035 CHANNELS=2, IMG_SIZE=4, ch1 = ch0+100 -> ch1 outputs {106,108,114,116} at addresses 4..7.
REQ-036 start re-pulsed while busy -> ignored; exactly OUT_SZ writes and one done pulse.
REQ-037 reset asserted at cycle 8 of a pass -> all outputs 0 that cycle, no writes, no done; a new start produces a correct full pass.
REQ-038 Window {-32768, 32767, 0, -1} -> out 32767; ties {7,7,7,7} -> out 7.
